mips_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the next-generation MIPS core. It replaces the bare PC register with a fetch unit that supports variable-latency instruction memory through a request/grant/response handshake. It holds a prefetch buffer of {pc, inst} pairs and supports branch/jump redirect with flush and in-flight discard. It also provides a drain-then-halt sequence. It sits between instruction memory and the DataPath decode stage.

---
 rtl/mips_fetch_pkg.sv | 17 +
 rtl/mips_fetch_unit_if.sv | 36 +++
 rtl/mips_fetch_ibuf.sv | 63 ++++++
 rtl/mips_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_mips_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared types and constants for the MIPS instruction-fetch front end.
//   fetch_state_t : fetch sequencer states (RUN, DRAIN, HALTED)
//   INST_BYTES    : byte stride between sequential instructions
//   INST_W        : instruction word width
// The {pc, inst} buffer entry type depends on ADDR_W, so it is declared in the user module.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } fetch_state_t;

    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned INST_W     = 32;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: fetch-unit bus bundle.
//   imem_*  : request/grant/response handshake towards instruction memory
//   inst_*  : valid/ready instruction stream towards the decode stage
// master = fetch unit side, slave = memory + decode side.
interface mips_fetch_unit_if
    import mips_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) ();

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;

    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/mips_fetch_ibuf.sv
// mips_fetch_ibuf: synchronous FIFO holding prefetched {pc, inst} entries.
//   clk, rst_b  : clock, synchronous active-high reset
//   push, din   : write an entry (ignored when full)
//   pop, dout   : consume head entry; dout always shows the head
//   flush       : empty the FIFO; wins over a simultaneous push
//   empty, full, count : occupancy status
module mips_fetch_ibuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        dout    = mem[rd_ptr];
    end

    // Storage needs no reset; stale data is never visible once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: instruction-fetch front end with prefetch buffer, redirect and halt.
//   clk, rst_b      : clock, synchronous active-high reset (1 = reset despite the name)
//   bus (master)    : imem request/grant/response and inst valid/ready stream
//   redirect_valid  : taken branch/jump; redirect_pc is the target (low two bits ignored)
//   halt_req        : start drain-then-halt; wins over a same-cycle redirect
//   halted          : registered, high once all in-flight fetches have returned
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int unsigned        IBUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_b,
    mips_fetch_unit_if.master     bus,
    input  logic                  redirect_valid,
    input  logic [ADDR_W-1:0]     redirect_pc,
    input  logic                  halt_req,
    output logic                  halted
);

    localparam int unsigned      CW      = $clog2(IBUF_DEPTH) + 1;
    localparam logic [CW:0]      DEPTH_L = (CW + 1)'(IBUF_DEPTH);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(INST_BYTES);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } ibuf_entry_t;

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;      // address tag of the next accepted response
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard_cnt;

    logic [CW-1:0]     outstanding_nxt;
    logic [CW:0]       inflight;
    logic [ADDR_W-1:0] target;
    logic              in_run;
    logic              issue;
    logic              resp;
    logic              push;
    logic              pop;
    logic              flush;
    logic              take_halt;
    logic              take_redirect;

    ibuf_entry_t       ib_din;
    ibuf_entry_t       ib_dout;
    logic              ib_empty;
    logic              ib_full;
    logic [CW-1:0]     ib_count;

    always_comb begin
        in_run        = (state == RUN);
        take_halt     = in_run & halt_req;
        take_redirect = in_run & redirect_valid & ~halt_req;
        target        = redirect_pc & ~ADDR_W'(INST_BYTES - 1);
        // Buffered plus in-flight never exceeds the buffer, so a response always has a slot.
        inflight      = {1'b0, ib_count} + {1'b0, outstanding};

        bus.imem_req  = ~rst_b & in_run & ~redirect_valid & (inflight < DEPTH_L);
        bus.imem_addr = fetch_pc;
        issue         = bus.imem_req & bus.imem_gnt;

        // A response with nothing outstanding is a protocol error and is ignored.
        resp          = bus.imem_rvalid & (outstanding != '0);
        push          = resp & in_run & (discard_cnt == '0);
        outstanding_nxt = outstanding + CW'(issue) - CW'(resp);

        bus.inst_valid = in_run & ~ib_empty;
        bus.inst       = ib_dout.inst;
        bus.inst_pc    = ib_dout.pc;
        pop            = bus.inst_valid & bus.inst_ready;
        flush          = ~in_run | take_halt | take_redirect;

        ib_din.pc      = resp_pc;
        ib_din.inst    = bus.imem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            halted      <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            if (resp && discard_cnt != '0) begin
                discard_cnt <= discard_cnt - CW'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + STEP;
            end
            if (issue) begin
                fetch_pc <= fetch_pc + STEP;
            end
            case (state)
                RUN: begin
                    if (take_halt) begin
                        state <= DRAIN;
                    end else if (take_redirect) begin
                        fetch_pc    <= target;
                        resp_pc     <= target;
                        // Everything still in flight after this cycle belongs to the old path.
                        discard_cnt <= outstanding_nxt;
                    end
                end
                DRAIN: begin
                    if (outstanding_nxt == '0) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

    mips_fetch_ibuf #(
        .DEPTH (IBUF_DEPTH),
        .W     ($bits(ibuf_entry_t))
    ) u_ibuf (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (ib_din),
        .dout  (ib_dout),
        .empty (ib_empty),
        .full  (ib_full),
        .count (ib_count)
    );

    a_rvalid_has_credit : assert property (
        @(posedge clk) disable iff (rst_b) !(bus.imem_rvalid && outstanding == '0));

    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (rst_b) !(push && ib_full && !pop && !flush));

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed bench for mips_fetch_unit with an in-order memory model.
// Issued fetches are queued by a negedge monitor; the memory responds one cycle after
// issue when enabled. Responses the bench expects to reach decode are pushed onto a
// scoreboard that the monitor pops and compares on every valid & ready.
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;

    always #5 clk = ~clk;

    mips_fetch_unit_if #(.ADDR_W(32)) bus ();

    mips_fetch_unit #(
        .ADDR_W     (32),
        .RESET_PC   (32'h0000_0000),
        .IBUF_DEPTH (4)
    ) u_dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted)
    );

    typedef struct {
        logic [31:0] addr;
        bit          keep;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    pend_t       pend[$];
    exp_t        exp_q[$];
    int          tests  = 0;
    int          fails  = 0;
    int          n_issue = 0;
    int          n_pop   = 0;
    bit          resp_en = 1'b0;
    logic [31:0] exp_pc  = 32'h0;
    int          base;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: advance past the edge, then let the memory model drive this cycle's response.
    task automatic tick();
        pend_t e;
        @(posedge clk);
        #1;
        if (resp_en && pend.size() != 0) begin
            e = pend.pop_front();
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(e.addr);
            if (e.keep) exp_q.push_back('{pc: e.addr, inst: mem_word(e.addr)});
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
        end
    endtask

    task automatic drop_inflight();
        foreach (pend[i]) pend[i].keep = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 50; k++) begin
            if (pend.size() == 0 && exp_q.size() == 0 && bus.inst_valid !== 1'b1 &&
                bus.imem_rvalid !== 1'b1) break;
            tick();
        end
        tests++;
        if (k == 50) begin
            fails++;
            $display("FAIL %s: still busy after 50 cycles, pending %0d, expected 0",
                     name, pend.size() + exp_q.size());
        end
    endtask

    // Monitor: issued address against the PC model, popped instructions against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_b === 1'b0) begin
            if (bus.imem_req === 1'b1 && bus.imem_gnt === 1'b1) begin
                check("issue_addr", bus.imem_addr, exp_pc);
                pend.push_back('{addr: bus.imem_addr, keep: 1'b1});
                exp_pc = exp_pc + 32'd4;
                n_issue++;
            end
            if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pop: got pc %h, expected no instruction",
                             bus.inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", bus.inst_pc, e.pc);
                    check("pop_inst", bus.inst, e.inst);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_b           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        halt_req        = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.inst_ready  = 1'b0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_req", 32'(bus.imem_req), 32'h0);
        check("rst_valid", 32'(bus.inst_valid), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);

        // Streaming: issue at c0, response at c1, instruction visible at c2
        tick();
        rst_b = 1'b0; bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1; resp_en = 1'b1;
        @(negedge clk);
        check("lat_c0_valid", 32'(bus.inst_valid), 32'h0);
        check("lat_c0_addr", bus.imem_addr, 32'h0);
        tick();
        @(negedge clk);
        check("lat_c1_valid", 32'(bus.inst_valid), 32'h0);
        check("lat_c1_addr", bus.imem_addr, 32'h4);
        tick();
        @(negedge clk);
        check("lat_c2_valid", 32'(bus.inst_valid), 32'h1);
        check("lat_c2_pc", bus.inst_pc, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            check("stream_valid", 32'(bus.inst_valid), 32'h1);
        end
        tick();
        bus.imem_gnt = 1'b0;
        wait_idle("stream_drain");
        check("stream_count", 32'(n_pop), 32'(n_issue));

        // Back-pressure: exactly IBUF_DEPTH issues, then one refill per pop
        tick();
        bus.inst_ready = 1'b0; bus.imem_gnt = 1'b1; base = n_issue;
        repeat (8) tick();
        @(negedge clk);
        check("full_issues", 32'(n_issue - base), 32'd4);
        check("full_req", 32'(bus.imem_req), 32'h0);
        check("full_valid", 32'(bus.inst_valid), 32'h1);
        for (int p = 0; p < 2; p++) begin
            tick();
            bus.inst_ready = 1'b1; base = n_issue;
            tick();
            bus.inst_ready = 1'b0;
            repeat (3) tick();
            @(negedge clk);
            check("refill_issues", 32'(n_issue - base), 32'd1);
            check("refill_req", 32'(bus.imem_req), 32'h0);
        end
        tick();
        bus.imem_gnt = 1'b0; bus.inst_ready = 1'b1;
        wait_idle("full_drain");

        // Redirect with 3 fetches in flight: old responses must be dropped
        tick();
        resp_en = 1'b0; bus.imem_gnt = 1'b1;
        repeat (3) tick();
        bus.imem_gnt = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; bus.imem_gnt = 1'b1;
        drop_inflight();
        exp_pc = 32'h0000_0100;
        @(negedge clk);
        check("redir_req", 32'(bus.imem_req), 32'h0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_addr", bus.imem_addr, 32'h0000_0100);
        check("redir_req_after", 32'(bus.imem_req), 32'h1);
        base = n_pop;
        tick();
        bus.imem_gnt = 1'b0; resp_en = 1'b1;
        wait_idle("redir_drain");
        check("redir_pops", 32'(n_pop - base), 32'd1);

        // Address wrap at the top of the address space
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        exp_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0; bus.imem_gnt = 1'b1;
        @(negedge clk);
        check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        check("wrap_addr1", bus.imem_addr, 32'h0000_0000);
        tick();
        bus.imem_gnt = 1'b0;
        wait_idle("wrap_drain");

        // Halt with one buffered instruction and 2 fetches outstanding
        tick();
        bus.inst_ready = 1'b0; bus.imem_gnt = 1'b1; resp_en = 1'b1;
        tick();
        resp_en = 1'b0;
        tick();
        tick();
        bus.imem_gnt = 1'b0; halt_req = 1'b1;
        @(negedge clk);
        check("halt_valid_before", 32'(bus.inst_valid), 32'h1);
        drop_inflight();
        exp_q.delete();
        tick();
        halt_req = 1'b0; resp_en = 1'b1; bus.inst_ready = 1'b1;
        @(negedge clk);
        check("drain_req", 32'(bus.imem_req), 32'h0);
        check("drain_valid", 32'(bus.inst_valid), 32'h0);
        check("drain_halted", 32'(halted), 32'h0);
        tick();
        tick();
        @(negedge clk);
        check("halt_wait", 32'(halted), 32'h0);
        check("halt_last_rvalid", 32'(bus.imem_rvalid), 32'h1);
        tick();
        @(negedge clk);
        check("halted_set", 32'(halted), 32'h1);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; bus.imem_gnt = 1'b1;
        @(negedge clk);
        check("halted_redir_req", 32'(bus.imem_req), 32'h0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("halted_ignore_req", 32'(bus.imem_req), 32'h0);
        check("halted_hold", 32'(halted), 32'h1);

        // Reset out of HALTED restarts at RESET_PC
        tick();
        rst_b = 1'b1; bus.imem_gnt = 1'b0;
        pend.delete();
        exp_q.delete();
        tick();
        rst_b = 1'b0; exp_pc = 32'h0; bus.imem_gnt = 1'b1;
        @(negedge clk);
        check("restart_halted", 32'(halted), 32'h0);
        check("restart_req", 32'(bus.imem_req), 32'h1);
        check("restart_addr", bus.imem_addr, 32'h0);
        tick();
        bus.imem_gnt = 1'b0;
        wait_idle("restart_drain");

        // Halt beats a simultaneous redirect
        tick();
        halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        halt_req = 1'b0; redirect_valid = 1'b0; bus.imem_gnt = 1'b1;
        @(negedge clk);
        check("hr_req", 32'(bus.imem_req), 32'h0);
        check("hr_halted_c1", 32'(halted), 32'h0);
        tick();
        @(negedge clk);
        check("hr_halted_c2", 32'(halted), 32'h1);
        check("hr_req_c2", 32'(bus.imem_req), 32'h0);
        check("final_scoreboard", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
